// File: rtl/q_meter_pkg.sv
// q_meter_pkg: shared types and defaults for the Q measurement front-end.
//   q_meter_state_t : measurement FSM states
//   *_DEF           : default bus width, settling interval and averaging depth
//   acc_width()     : accumulator width that holds 2**log2_avg full-scale samples
package q_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACQUIRE,
    ST_DONE
  } q_meter_state_t;

  localparam int unsigned BUS_WIDTH_DEF     = 10;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned LOG2_AVG_DEF      = 3;

  // Summing 2**log2_avg unsigned values needs log2_avg extra bits to be overflow-free.
  function automatic int unsigned acc_width(input int unsigned bus_width,
                                            input int unsigned log2_avg);
    return bus_width + log2_avg;
  endfunction

endpackage

// File: rtl/q_meter_if.sv
// q_meter_if: controller/sensor side bundle of the Q meter.
//   enable, i_ref, sample, sample_valid : towards the meter
//   q_measured, ready                   : from the meter
// modport master : the environment (controller + sensing datapath)
// modport slave  : the q_meter block
interface q_meter_if import q_meter_pkg::*; #(
  parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF
);
  logic                 enable;
  logic [BUS_WIDTH-1:0] i_ref;
  logic [BUS_WIDTH-1:0] sample;
  logic                 sample_valid;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 ready;

  modport master (
    output enable, i_ref, sample, sample_valid,
    input  q_measured, ready
  );

  modport slave (
    input  enable, i_ref, sample, sample_valid,
    output q_measured, ready
  );
endinterface

// File: rtl/q_accum.sv
// q_accum: sample accumulator for one averaged measurement.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : zero the sum and the sample count (wins over add)
//   add        : accept sample this cycle
//   sample     : unsigned sample value
//   full       : the sample accepted this cycle is the 2**LOG2_AVG-th one
//   mean_next  : floor mean of the sum including this cycle's sample
module q_accum import q_meter_pkg::*; #(
  parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int unsigned LOG2_AVG  = LOG2_AVG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 add,
  input  logic [BUS_WIDTH-1:0] sample,
  output logic                 full,
  output logic [BUS_WIDTH-1:0] mean_next
);
  localparam int unsigned ACC_W = acc_width(BUS_WIDTH, LOG2_AVG);
  localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** LOG2_AVG) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_next;

  assign sum_next  = acc + ACC_W'(sample);
  // The FSM latches the result on the same edge that accepts the last sample,
  // so the mean is taken from the sum including that sample.
  assign mean_next = BUS_WIDTH'(sum_next >> LOG2_AVG);
  assign full      = add && (cnt == LAST);

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) so every flop sees pre-edge values.
    if (!rst || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= sum_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/q_meter.sv
// q_meter: waits SETTLE_CYCLES after each new i_ref, averages 2**LOG2_AVG valid
// samples and reports the floor mean on q_measured with a one-cycle ready pulse.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : q_meter_if.slave (enable, i_ref, sample, sample_valid -> q_measured, ready)
// Build option: define Q_METER_RESTART_EN to abort and restart a measurement when
// i_ref changes during SETTLE/ACQUIRE; otherwise the change is taken up afterwards.
module q_meter import q_meter_pkg::*; #(
  parameter int unsigned BUS_WIDTH     = BUS_WIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned LOG2_AVG      = LOG2_AVG_DEF
) (
  input logic      clk,
  input logic      rst,
  q_meter_if.slave bus
);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  // With no settling interval a measurement starts directly in ACQUIRE.
  localparam q_meter_state_t ENTRY_STATE = (SETTLE_CYCLES == 0) ? ST_ACQUIRE : ST_SETTLE;

  q_meter_state_t       state, state_next;
  logic [BUS_WIDTH-1:0] i_ref_q;
  logic                 first;
  logic [SET_W-1:0]     settle_cnt;
  logic [BUS_WIDTH-1:0] q_measured_r;
  logic                 ready_r;

  logic                 ref_changed, request, restart, start;
  logic                 acc_clear, acc_add, acc_full;
  logic [BUS_WIDTH-1:0] acc_mean;

  assign ref_changed = (bus.i_ref != i_ref_q);
  assign request     = bus.enable && (first || ref_changed);

`ifdef Q_METER_RESTART_EN
  assign restart = bus.enable && ref_changed &&
                   ((state == ST_SETTLE) || (state == ST_ACQUIRE));
`else
  assign restart = 1'b0;
`endif

  // Kept outside the FSM block so acc_full -> state_next has no path back into acc_add.
  assign acc_add   = bus.enable && !restart && (state == ST_ACQUIRE) && bus.sample_valid;
  assign acc_clear = !bus.enable || start;

  q_accum #(
    .BUS_WIDTH (BUS_WIDTH),
    .LOG2_AVG  (LOG2_AVG)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .add       (acc_add),
    .sample    (bus.sample),
    .full      (acc_full),
    .mean_next (acc_mean)
  );

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    state_next = state;
    start      = 1'b0;
    if (!bus.enable) begin
      state_next = ST_IDLE;
    end else if (restart) begin
      start      = 1'b1;
      state_next = ENTRY_STATE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (request) begin
            start      = 1'b1;
            state_next = ENTRY_STATE;
          end
        end
        ST_SETTLE:  if (settle_cnt == SET_W'(1)) state_next = ST_ACQUIRE;
        ST_ACQUIRE: if (acc_full) state_next = ST_DONE;
        ST_DONE:    state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      i_ref_q      <= '0;
      first        <= 1'b1;
      settle_cnt   <= '0;
      q_measured_r <= '0;
      ready_r      <= 1'b0;
    end else begin
      state <= state_next;
      // ready and q_measured are registered on entry to DONE so both are
      // visible exactly during the DONE cycle.
      ready_r <= (state_next == ST_DONE);
      if (state_next == ST_DONE) q_measured_r <= acc_mean;
      if (start) begin
        i_ref_q    <= bus.i_ref;
        first      <= 1'b0;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end
    end
  end

  assign bus.q_measured = q_measured_r;
  assign bus.ready      = ready_r;

endmodule

// File: doc/q_meter.md
# q_meter

Measurement front-end that produces the `q_measured`/`ready` pair consumed by the bisection current controller. It watches the controller's `i_ref` output, and after every new reference value it waits a settling interval, then averages a power-of-two number of samples from the Q-sensing datapath. It presents the mean as `q_measured` with a one-cycle `ready` pulse. It sits between the sensor sample stream and the controller, closing the bisection loop.

## Interface
- `BUS_WIDTH`, 10, width of `i_ref`, `sample` and `q_measured`
- `SETTLE_CYCLES`, 16, cycles to wait after a reference change before sampling; 0 is legal and skips settling
- `LOG2_AVG`, 3, log2 of samples averaged per measurement (N = 2**LOG2_AVG)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `enable`  in  1  block enable; low aborts and idles
- `i_ref`  in  BUS_WIDTH  reference current from the controller
- `sample`  in  BUS_WIDTH  unsigned Q sample from the sensing datapath
- `sample_valid`  in  1  `sample` is valid this cycle
- `q_measured`  out  BUS_WIDTH  registered averaged Q; held between measurements
- `ready`  out  1  registered one-cycle pulse; `q_measured` is new this cycle

## Operation
- States: IDLE, SETTLE, ACQUIRE, DONE.
- Internal registers:
  - `i_ref_q`: last reference measured.
  - `first`: set by reset; forces the first measurement.
  - settle counter.
  - sample counter, LOG2_AVG bits.
  - accumulator, BUS_WIDTH+LOG2_AVG bits unsigned; it cannot overflow.
- Request = `enable && (first || i_ref != i_ref_q)`.
- IDLE → SETTLE on a request:
  - latch `i_ref_q <= i_ref`, clear `first`.
  - load settle counter with SETTLE_CYCLES; clear accumulator and sample counter.
  - If SETTLE_CYCLES == 0, go directly to ACQUIRE.
- SETTLE: decrement each cycle; after exactly SETTLE_CYCLES cycles in SETTLE, go to ACQUIRE.
- ACQUIRE:
  - Each cycle with `sample_valid`: accumulator += `sample`, sample counter += 1. Cycles without `sample_valid` stretch acquisition.
  - When the Nth valid sample is accepted, go to DONE.
- DONE (one cycle): `q_measured <= acc >> LOG2_AVG` (floor), `ready` = 1. Next state is IDLE.
- `ready` is 1 only in DONE.
- Once back in IDLE, an unchanged `i_ref` produces no further measurement.
- `enable` low in any state:
  - next state IDLE, accumulator cleared, `ready` 0.
  - `q_measured` and `i_ref_q` held.
  - `first` is unchanged.
- A change of `i_ref` during SETTLE/ACQUIRE is handled per Configuration.

## Timing
- Reset values: `q_measured` = 0, `ready` = 0, state IDLE, `i_ref_q` = 0, `first` = 1, counters and accumulator 0.
- Reset has priority over `enable` and all other inputs.
- Request seen in cycle t: SETTLE occupies t+1..t+S. ACQUIRE starts at t+S+1.
- With continuous `sample_valid`, samples are taken at t+S+1..t+S+N and `ready` is high at t+S+N+1. Defaults: `ready` at t+25.
- `ready` never lasts more than one cycle; minimum spacing between pulses is S+N+2 cycles.
- `q_measured` changes only in the `ready` cycle.

## Configuration
- `Q_METER_RESTART_EN` defined: an `i_ref` change during SETTLE or ACQUIRE aborts the measurement:
  - relatch `i_ref_q`, reload settle counter, clear accumulator and sample counter, re-enter SETTLE.
  - No `ready` is issued for the aborted measurement.
- Not defined: mid-measurement changes are ignored.
  - The current measurement completes and reports through `ready`.
  - The new value is then picked up from IDLE as a normal request in the cycle after DONE.

## Structure
- Package `q_meter_pkg` holds:
  - the state enum typedef `q_meter_state_t`;
  - default constants for SETTLE_CYCLES and LOG2_AVG;
  - the derived accumulator width function.
- One sub-module, `q_accum`: clear/accumulate/count with a `full` flag after N samples.
- The FSM and the `i_ref` change detection stay in `q_meter`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `enable` = 1 → `ready` = 0, `q_measured` = 0; measurement starts only after release.
- Constant input: `enable` = 1, `i_ref` = 512, `sample` = 300 continuously valid → a single `ready` pulse 25 cycles after the request, `q_measured` = 300; no further pulse while `i_ref` is held.
- Averaging: samples 0..7, with `sample_valid` deasserted every other cycle → `ready` at request+33, `q_measured` = 3 (floor of 28/8). Separately, eight samples of 1023 → 1023, no overflow.
- New reference: after the first result, change `i_ref` 512 → 256 → second `ready` 25 cycles later with the new mean.
- Mid-ACQUIRE change at cycle 20:
  - with `Q_METER_RESTART_EN`: no `ready` at 25; `ready` at 20+25 = 45.
  - without it: `ready` at 25, then again at 26+25 = 51.
- `enable` dropped during SETTLE for 3 cycles → no `ready`, `q_measured` held. On re-enable with `i_ref` unchanged and `first` cleared, no measurement starts until `i_ref` changes.
